pwm_deadtime: RTL
=================

# pwm_deadtime

Complementary-output dead-time generator directly downstream of the PWM generator. Consumes the single-ended PWM waveform and drives a high-side / low-side gate-drive pair. Guarantees the two outputs are never active together and that a programmable all-off gap separates every hand-over. Adds a latched fault shutdown path. Both outputs are Moore outputs of a registered state machine, so they are glitch-free.

## Interface
- WIDTH, 16: width of the dead-time count.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = drive outputs; 0 = both outputs off.
- pwm_in  in  1  PWM waveform from the PWM generator, same clock domain.
- dead_time  in  WIDTH  all-off gap in clk cycles; 0 is treated as 1.
- fault  in  1  active-high shutdown request, level-sensitive.
- fault_clr  in  1  single-cycle request to leave the fault state.
- hs_out  out  1  high-side drive.
- ls_out  out  1  low-side drive.
- dead_active  out  1  1 while in the DEAD state.
- fault_latched  out  1  1 while in the FAULT state.

## Operation
- pwm_in is registered once into pwm_q. pwm_q drives all next-state decisions.
- States:
  - OFF: both outputs 0.
  - HS_ON: hs_out=1.
  - LS_ON: ls_out=1.
  - DEAD: both outputs 0, dead_active=1.
  - FAULT: both outputs 0, fault_latched=1.
- Transition priority, highest first:
  1. fault=1 in any state → FAULT.
  2. enable=0 in any state except FAULT → OFF.
  3. The per-state rules below.
- OFF with enable=1 → DEAD.
- HS_ON with pwm_q=0 → DEAD.
- LS_ON with pwm_q=1 → DEAD.
- Entering DEAD loads dt_cnt with dead_time, or with 1 if dead_time=0. dead_time is sampled only at entry; changes during DEAD are ignored.
- In DEAD, when dt_cnt==1 the block exits:
  - pwm_q=1 → HS_ON.
  - pwm_q=0 → LS_ON.
  - Otherwise dt_cnt decrements.
- The exit target is decided from pwm_q at expiry. A pwm_in pulse shorter than the dead time is swallowed.
- FAULT → OFF only when fault_clr=1 and fault=0 in the same cycle. fault_clr while fault=1 has no effect.
- After leaving FAULT, the block re-enters through OFF → DEAD, so the dead gap always applies.
- dt_cnt is an unsigned WIDTH-bit count. It never underflows because it is loaded with a value of at least 1.

## Timing
- Reset values: state=OFF, dt_cnt=0, pwm_q=0. All outputs are 0 (hs_out, ls_out, dead_active, fault_latched).
- pwm_in to output latency is 2 edges: edge k samples pwm_in into pwm_q, and edge k+1 updates the state and outputs.
- fault to outputs-off latency is 1 edge; fault is not registered.
- enable=0 to outputs-off latency is 1 edge.
- A DEAD interval lasts exactly max(dead_time,1) cycles with both outputs 0.
- Invariant: hs_out & ls_out = 0 on every cycle.
- Invariant: every hs↔ls change has at least max(dead_time,1) all-off cycles between them.
- Reset asserted mid-operation forces OFF asynchronously, and the outputs drop immediately.
- fault and enable=0 in the same cycle → FAULT.
- pwm_q toggles on the same edge that DEAD expires → the toggled value selects the target.

## Structure
- Shared package pwm_pkg holds:
  - the state enum (OFF, DEAD, HS_ON, LS_ON, FAULT);
  - the reset-value constants;
  - the default WIDTH.
- One sub-module, pwm_dt_counter: a loadable down-counter with load, value, and an expire flag asserted when the count is 1.
- The FSM, the pwm_q register, and the output decode live in pwm_deadtime.

## Test plan
- Reset then enable=1, pwm_in=0, dead_time=4 → OFF, then DEAD for 4 cycles, then LS_ON. hs_out stays 0 throughout.
- 50% square wave on pwm_in with period 20, dead_time=3 → every edge is followed by 3 cycles of both outputs 0. hs_out is high 7 cycles per period (10 − 3), with 2-edge latency. No overlap is ever observed.
- dead_time=0 → exactly 1 all-off cycle per transition.
- dead_time=8 with a 5-cycle high pulse on pwm_in from LS_ON → the pulse is swallowed and the block returns to LS_ON. hs_out never rises.
- fault=1 while in HS_ON → both outputs 0 after 1 edge, fault_latched=1.
  - fault_clr with fault still 1 → no exit.
  - Drop fault, then fault_clr → OFF, then DEAD, then the PWM-selected state.
- Assert rst mid-DEAD, then release → outputs are 0 immediately. The block restarts from OFF and the full dead_time is applied.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the complementary dead-time generator.
package pwm_pkg;

  localparam int DT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_HS_ON = 3'd2,
    ST_LS_ON = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam state_t RST_STATE = ST_OFF;
  localparam logic   RST_PWM_Q = 1'b0;
  localparam logic   RST_OUT   = 1'b0;

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter timing the all-off gap; o_expire flags the final gap cycle.
module pwm_dt_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_value,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  // Load wins over decrement; the zero guard keeps the count from wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_value  = r_cnt;
  assign o_expire = (r_cnt == WIDTH'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low-side driver with programmable dead gap and latched fault.
// Handshake-free block: inputs are levels sampled every rising edge, outputs are registered Moore decodes.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int WIDTH = DT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic [WIDTH-1:0] dead_time,
  input  logic             fault,
  input  logic             fault_clr,
  output logic             hs_out,
  output logic             ls_out,
  output logic             dead_active,
  output logic             fault_latched,
  output state_t           o_state_dbg,
  output logic [WIDTH-1:0] o_dt_cnt_dbg
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pwm_q;
  logic             w_load;
  logic             w_dec;
  logic             w_expire;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_dt_cnt;
  logic             r_hs;
  logic             r_ls;
  logic             r_dead;
  logic             r_fault;

  // A zero dead time still yields one all-off cycle.
  assign w_load_val = (dead_time == '0) ? WIDTH'(1) : dead_time;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_q <= RST_PWM_Q;
    end else begin
      r_pwm_q <= pwm_in;
    end
  end

  pwm_dt_counter #(
    .WIDTH(WIDTH)
  ) u_dt_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .o_value   (w_dt_cnt),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fault beats enable, enable beats the per-state rules; FAULT ignores enable.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    if (fault) begin
      w_state_next = ST_FAULT;
    end else if (!enable && (r_state != ST_FAULT)) begin
      w_state_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_next = ST_DEAD;
          w_load       = 1'b1;
        end
        ST_HS_ON: begin
          if (!r_pwm_q) begin
            w_state_next = ST_DEAD;
            w_load       = 1'b1;
          end
        end
        ST_LS_ON: begin
          if (r_pwm_q) begin
            w_state_next = ST_DEAD;
            w_load       = 1'b1;
          end
        end
        ST_DEAD: begin
          if (w_expire) begin
            w_state_next = r_pwm_q ? ST_HS_ON : ST_LS_ON;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            w_state_next = ST_OFF;
          end
        end
        default: w_state_next = ST_OFF;
      endcase
    end
  end

  // Outputs are flopped from the next-state decode so they change with the state, glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs    <= RST_OUT;
      r_ls    <= RST_OUT;
      r_dead  <= RST_OUT;
      r_fault <= RST_OUT;
    end else begin
      r_hs    <= (w_state_next == ST_HS_ON);
      r_ls    <= (w_state_next == ST_LS_ON);
      r_dead  <= (w_state_next == ST_DEAD);
      r_fault <= (w_state_next == ST_FAULT);
    end
  end

  assign hs_out        = r_hs;
  assign ls_out        = r_ls;
  assign dead_active   = r_dead;
  assign fault_latched = r_fault;
  assign o_state_dbg   = r_state;
  assign o_dt_cnt_dbg  = w_dt_cnt;

endmodule
